// File: rtl/sr_latch_sequencer.sv
// Sequencer that drives a gated SR latch through setup / enable pulse / hold
// phases and then verifies the latch readback, reporting done/err.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a command, cmd_ready high, C/S/R low
// SETUP    | S or R asserted with C low, data settling before the pulse
// PULSE    | C high, S/R unchanged, latch is written
// HOLD     | C low again, S/R still stable after the enable falls
// CHECK    | one cycle: done high, err from readback, q_state update
module sr_latch_sequencer #(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_op,
    output logic       cmd_ready,
    output logic       C,
    output logic       S,
    output logic       R,
    input  logic       q_in,
    input  logic       qp_in,
    output logic       done,
    output logic       err,
    output logic       q_state
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_PULSE = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_CHECK = 3'd4;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_SET   = 2'b01;
    localparam logic [1:0] OP_RESET = 2'b10;
    localparam logic [1:0] OP_ILL   = 2'b11;

    // Terminal counts; each phase counter starts at 0 on entry.
    localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYC - 1);
    localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYC - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYC - 1);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [7:0] cnt;
    logic [1:0] op_q;
    logic       accept;
    logic       phase_last;
    logic       is_set;
    logic       is_rst;
    logic       drive_phase;

    assign cmd_ready = (state == ST_IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;

    assign is_set      = (op_q == OP_SET);
    assign is_rst      = (op_q == OP_RESET);
    assign drive_phase = (state == ST_SETUP) || (state == ST_PULSE) || (state == ST_HOLD);

    // Terminal-count detect for the currently timed phase.
    always_comb begin
        phase_last = 1'b0;
        case (state)
            ST_SETUP: phase_last = (cnt == SETUP_LAST);
            ST_PULSE: phase_last = (cnt == PULSE_LAST);
            ST_HOLD:  phase_last = (cnt == HOLD_LAST);
            default:  phase_last = 1'b0;
        endcase
    end

    // Next-state decode; read and illegal ops skip straight to CHECK.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if ((cmd_op == OP_SET) || (cmd_op == OP_RESET)) begin
                        state_nxt = ST_SETUP;
                    end else begin
                        state_nxt = ST_CHECK;
                    end
                end
            end
            ST_SETUP: if (phase_last) state_nxt = ST_PULSE;
            ST_PULSE: if (phase_last) state_nxt = ST_HOLD;
            ST_HOLD:  if (phase_last) state_nxt = ST_CHECK;
            ST_CHECK: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Latch-side outputs are pure state decode, so C can only rise in PULSE
    // and S/R are mutually exclusive by construction of the registered op.
    always_comb begin
        C    = (state == ST_PULSE);
        S    = drive_phase && is_set;
        R    = drive_phase && is_rst;
        done = (state == ST_CHECK);
        err  = (state == ST_CHECK) &&
               ((op_q == OP_ILL) ||
                (q_in == qp_in) ||
                (is_set && (q_in != 1'b1)) ||
                (is_rst && (q_in != 1'b0)));
    end

    // State, phase counter, captured op and verified latch value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= 8'd0;
            op_q    <= OP_READ;
            q_state <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state_nxt != state) || !drive_phase) begin
                cnt <= 8'd0;
            end else begin
                cnt <= cnt + 8'd1;
            end
            if (accept) begin
                op_q <= cmd_op;
            end
            if ((state == ST_CHECK) && !err) begin
                q_state <= q_in;
            end
        end
    end

endmodule

// File: tb/tb_sr_latch_sequencer.sv
// Bench for sr_latch_sequencer: a default-parameter instance driven through
// directed and random commands against a behavioural latch, plus a 3/4/2
// instance exercised back-to-back.
module tb_sr_latch_sequencer;

    localparam int SU = 1;
    localparam int PU = 2;
    localparam int HO = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic       cmd_ready, C, S, R, q_in, qp_in, done, err, q_state;

    logic       cmd_valid_b;
    logic [1:0] cmd_op_b;
    logic       cmd_ready_b, C_b, S_b, R_b, q_in_b, qp_in_b, done_b, err_b, q_state_b;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural gated SR latches; stuck selects a faulty readback.
    logic lat   = 1'b0;
    logic lat_b = 1'b0;
    int   stuck = 0;

    always @(posedge clk) begin
        if (C) begin
            if (S) lat <= 1'b1;
            else if (R) lat <= 1'b0;
        end
        if (C_b) begin
            if (S_b) lat_b <= 1'b1;
            else if (R_b) lat_b <= 1'b0;
        end
    end

    assign q_in    = (stuck == 1) ? 1'b1 : (stuck == 2) ? 1'b0 : lat;
    assign qp_in   = (stuck == 1) ? 1'b1 : (stuck == 2) ? 1'b0 : ~lat;
    assign q_in_b  = lat_b;
    assign qp_in_b = ~lat_b;

    sr_latch_sequencer dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_ready(cmd_ready), .C(C), .S(S), .R(R), .q_in(q_in), .qp_in(qp_in),
        .done(done), .err(err), .q_state(q_state)
    );

    sr_latch_sequencer #(.SETUP_CYC(3), .PULSE_CYC(4), .HOLD_CYC(2)) dut_b (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid_b), .cmd_op(cmd_op_b),
        .cmd_ready(cmd_ready_b), .C(C_b), .S(S_b), .R(R_b), .q_in(q_in_b), .qp_in(qp_in_b),
        .done(done_b), .err(err_b), .q_state(q_state_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // S and R must never be high together on either instance.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            check("sr_excl", {30'd0, S & R, S_b & R_b}, 32'd0);
        end
    end

    // Reference state: what the latch should hold and the last verified value.
    logic ref_lat    = 1'b0;
    logic ref_qstate = 1'b0;

    // One command on the default instance, checked cycle by cycle from the
    // accept edge using the phase lengths directly.
    task automatic run_cmd(input logic [1:0] op, input int stk, input string tag);
        int   len;
        bit   pulsed;
        logic exp_q, exp_qp, exp_err;
        logic eC, eS, eR, eD, eE;
        stuck  = stk;
        pulsed = (op == 2'b01) || (op == 2'b10);
        len    = pulsed ? (SU + PU + HO + 1) : 1;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        check({tag, " ready_before"}, {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom_range(0, 3));
        if (pulsed) ref_lat = (op == 2'b01);
        exp_q   = (stk == 1) ? 1'b1 : (stk == 2) ? 1'b0 : ref_lat;
        exp_qp  = (stk == 1) ? 1'b1 : (stk == 2) ? 1'b0 : ~ref_lat;
        exp_err = (op == 2'b11) || (exp_q == exp_qp) ||
                  ((op == 2'b01) && (exp_q != 1'b1)) ||
                  ((op == 2'b10) && (exp_q != 1'b0));
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            eC = pulsed && (k > SU) && (k <= SU + PU);
            eS = (op == 2'b01) && (k < len);
            eR = (op == 2'b10) && (k < len);
            eD = (k == len);
            eE = (k == len) && exp_err;
            check($sformatf("%s k=%0d C,S,R,done,err,ready", tag, k),
                  {26'd0, C, S, R, done, err, cmd_ready},
                  {26'd0, eC, eS, eR, eD, eE, 1'b0});
        end
        if (!exp_err) ref_qstate = exp_q;
        @(negedge clk);
        check({tag, " after q_state,done,ready"}, {29'd0, q_state, done, cmd_ready},
              {29'd0, ref_qstate, 1'b0, 1'b1});
    endtask

    initial begin
        int   dones;
        int   kk;
        logic [1:0] rop;
        int   rstk;
        rst         = 1'b1;
        cmd_valid   = 1'b1;
        cmd_op      = 2'b01;
        cmd_valid_b = 1'b0;
        cmd_op_b    = 2'b00;

        // Reset state, with a command offered that must not be taken.
        repeat (3) begin
            @(negedge clk);
            check("reset outputs", {25'd0, C, S, R, done, err, q_state, cmd_ready}, 32'd0);
            check("reset outputs b", {25'd0, C_b, S_b, R_b, done_b, err_b, q_state_b, cmd_ready_b}, 32'd0);
        end
        @(posedge clk);
        #1;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("post reset ready,C", {30'd0, cmd_ready, C}, {30'd0, 1'b1, 1'b0});

        // Directed commands.
        run_cmd(2'b01, 0, "set");
        run_cmd(2'b10, 0, "reset");
        run_cmd(2'b01, 1, "stuck_set");
        run_cmd(2'b11, 0, "illegal");
        run_cmd(2'b01, 0, "set2");
        run_cmd(2'b00, 0, "read");

        // Reset asserted mid-pulse aborts the command silently.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("abort k=1 C,S,R", {29'd0, C, S, R}, {29'd0, 3'b001});
        @(negedge clk);
        check("abort k=2 C,S,R", {29'd0, C, S, R}, {29'd0, 3'b101});
        rst = 1'b1;
        @(negedge clk);
        check("abort in reset", {25'd0, C, S, R, done, err, q_state, cmd_ready}, 32'd0);
        ref_lat    = 1'b0;
        ref_qstate = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("abort released C,done,ready", {29'd0, C, done, cmd_ready}, {29'd0, 3'b001});

        // Random commands with occasional faulty latch readback.
        for (int i = 0; i < 40; i++) begin
            rop  = 2'($urandom_range(0, 3));
            rstk = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0;
            run_cmd(rop, rstk, $sformatf("rnd%0d op=%0d stk=%0d", i, rop, rstk));
        end
        stuck = 0;

        // Back-to-back sets on the 3/4/2 instance: period 11 cycles.
        @(negedge clk);
        check("b2b ready", {31'd0, cmd_ready_b}, 32'd1);
        cmd_valid_b = 1'b1;
        cmd_op_b    = 2'b01;
        dones = 0;
        for (int n = 1; n <= 44; n++) begin
            @(negedge clk);
            kk = n % 11;
            if (done_b) dones++;
            check($sformatf("b2b n=%0d C,S,R,done,err,ready", n),
                  {26'd0, C_b, S_b, R_b, done_b, err_b, cmd_ready_b},
                  {26'd0, (kk >= 4) && (kk <= 7), (kk >= 1) && (kk <= 9), 1'b0,
                   kk == 10, 1'b0, kk == 0});
        end
        cmd_valid_b = 1'b0;
        check("b2b done count", dones, 32'd4);
        check("b2b q_state", {31'd0, q_state_b}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
